// File: rtl/alu_seq_if.sv
// Start/busy/done handshake and operand bus between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             alu_start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_AI;
  logic [WIDTH-1:0] alu_BI;
  logic             alu_carry;
  logic             alu_BCD;
  logic             alu_busy;
  logic             alu_done;
  logic             alu_err;
  logic [7:0]       alu_flags;
  logic [WIDTH-1:0] alu_Y;

  modport master (
    output alu_start, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD,
    input  alu_busy, alu_done, alu_err, alu_flags, alu_Y
  );

  modport slave (
    input  alu_start, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD,
    output alu_busy, alu_done, alu_err, alu_flags, alu_Y
  );
endinterface

// File: rtl/alu_seq.sv
// 6502 ALU with N/V/Z/C status: binary/logic ops finish in 1 cycle, decimal ADC/SBC in WIDTH/4 cycles.
// Starts are accepted only while alu_busy=0; a start during a decimal run is dropped, not queued.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_ORA = 4'h1;
  localparam logic [3:0] OP_EOR = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_LSR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_ROL = 4'h6;
  localparam logic [3:0] OP_ROR = 4'h7;
  localparam logic [3:0] OP_SBC = 4'h8;

  typedef enum logic {IDLE, BCD_RUN} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       flags_q, flags_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic             sbc_q, sbc_d;
  logic             v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Binary add path; also supplies V for decimal mode, which follows the binary sum.
  logic             is_sbc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   bin_sum;
  logic             bin_v;

  always_comb begin
    is_sbc  = (bus.alu_ctrl == OP_SBC);
    b_eff   = is_sbc ? ~bus.alu_BI : bus.alu_BI;
    bin_sum = {1'b0, bus.alu_AI} + {1'b0, b_eff} + (WIDTH+1)'(bus.alu_carry);
    bin_v   = (bus.alu_AI[WIDTH-1] ^ bin_sum[WIDTH-1]) & (b_eff[WIDTH-1] ^ bin_sum[WIDTH-1]);
  end

  // One decimal digit per cycle; operands shift right so the active digit is always [3:0].
  logic [4:0]       dig_s;
  logic [3:0]       dig_r;
  logic             dig_c;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    dig_c = 1'b0;
    if (sbc_q) begin
      dig_s = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, cy_q};
      if (dig_s[4]) begin
        dig_s = dig_s + 5'd10;
        dig_c = 1'b1;
      end
    end else begin
      dig_s = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, cy_q};
      if (dig_s > 5'd9) begin
        dig_s = dig_s + 5'd6;
        dig_c = 1'b1;
      end
    end
    dig_r   = dig_s[3:0];
    acc_nxt = (acc_q >> 4) | (WIDTH'(dig_r) << (WIDTH - 4));
  end

  logic [WIDTH-1:0] op_y;
  logic             op_c;
  logic             op_v;
  logic             reserved;
  logic             fin_c;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    flags_d  = flags_q;
    y_d      = y_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    sbc_d    = sbc_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    op_y     = y_q;
    op_c     = flags_q[0];
    op_v     = flags_q[6];
    reserved = 1'b0;
    fin_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.alu_start) begin
          if ((bus.alu_ctrl == OP_ADC || is_sbc) && bus.alu_BCD) begin
            a_d     = bus.alu_AI;
            b_d     = bus.alu_BI;
            sbc_d   = is_sbc;
            cy_d    = is_sbc ? ~bus.alu_carry : bus.alu_carry;
            v_d     = bin_v;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = BCD_RUN;
          end else begin
            done_d = 1'b1;
            case (bus.alu_ctrl)
              OP_ADC, OP_SBC: begin
                op_y = bin_sum[WIDTH-1:0];
                op_c = bin_sum[WIDTH];
                op_v = bin_v;
              end
              OP_ORA: op_y = bus.alu_AI | bus.alu_BI;
              OP_EOR: op_y = bus.alu_AI ^ bus.alu_BI;
              OP_AND: op_y = bus.alu_AI & bus.alu_BI;
              OP_LSR: begin
                op_y = bus.alu_AI >> 1;
                op_c = bus.alu_AI[0];
              end
              OP_ASL: begin
                op_y = bus.alu_AI << 1;
                op_c = bus.alu_AI[WIDTH-1];
              end
              OP_ROL: begin
                op_y = {bus.alu_AI[WIDTH-2:0], bus.alu_carry};
                op_c = bus.alu_AI[WIDTH-1];
              end
              OP_ROR: begin
                op_y = {bus.alu_carry, bus.alu_AI[WIDTH-1:1]};
                op_c = bus.alu_AI[0];
              end
              default: reserved = 1'b1;
            endcase
            err_d = reserved;
            if (!reserved) begin
              y_d     = op_y;
              flags_d = {op_y[WIDTH-1], op_v, 4'b0000, (op_y == '0), op_c};
            end
          end
        end
      end
      BCD_RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cy_d  = dig_c;
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          fin_c   = sbc_q ? ~dig_c : dig_c;
          y_d     = acc_nxt;
          flags_d = {acc_nxt[WIDTH-1], v_q, 4'b0000, (acc_nxt == '0), fin_c};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flags_q <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      sbc_q   <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flags_q <= flags_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      sbc_q   <= sbc_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.alu_busy  = busy_q;
  assign bus.alu_done  = done_q;
  assign bus.alu_err   = err_q;
  assign bus.alu_flags = flags_q;
  assign bus.alu_Y     = y_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16 with hand-computed directed vectors.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  f;
    logic        e;
    int          due;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t m8;
  exp_t m16;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && if8.alu_done) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u8 spurious done: got y=%0h at cycle %0d expected no completion", if8.alu_Y, cyc);
      end else begin
        m8 = q8.pop_front();
        chk("u8 y", 32'(if8.alu_Y), 32'(m8.y));
        chk("u8 flags", 32'(if8.alu_flags), 32'(m8.f));
        chk("u8 err", 32'(if8.alu_err), 32'(m8.e));
        chk("u8 done cycle", cyc, m8.due);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if16.alu_done) begin
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u16 spurious done: got y=%0h at cycle %0d expected no completion", if16.alu_Y, cyc);
      end else begin
        m16 = q16.pop_front();
        chk("u16 y", 32'(if16.alu_Y), 32'(m16.y));
        chk("u16 flags", 32'(if16.alu_flags), 32'(m16.f));
        chk("u16 err", 32'(if16.alu_err), 32'(m16.e));
        chk("u16 done cycle", cyc, m16.due);
      end
    end
  end

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic bcd, input bit exp_done,
                        input logic [7:0] ey, input logic [7:0] ef, input logic ee);
    exp_t e;
    if (exp_done) begin
      e.y   = 16'(ey);
      e.f   = ef;
      e.e   = ee;
      e.due = cyc + ((bcd && (op == 4'h0 || op == 4'h8)) ? 3 : 1);
      q8.push_back(e);
    end
    if8.alu_ctrl  = op;
    if8.alu_AI    = a;
    if8.alu_BI    = b;
    if8.alu_carry = c;
    if8.alu_BCD   = bcd;
    if8.alu_start = 1'b1;
    @(posedge clk);
    #1;
    if8.alu_start = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic bcd,
                         input logic [15:0] ey, input logic [7:0] ef, input logic ee);
    exp_t e;
    e.y   = ey;
    e.f   = ef;
    e.e   = ee;
    e.due = cyc + ((bcd && (op == 4'h0 || op == 4'h8)) ? 5 : 1);
    q16.push_back(e);
    if16.alu_ctrl  = op;
    if16.alu_AI    = a;
    if16.alu_BI    = b;
    if16.alu_carry = c;
    if16.alu_BCD   = bcd;
    if16.alu_start = 1'b1;
    @(posedge clk);
    #1;
    if16.alu_start = 1'b0;
  endtask

  task automatic bcd_wait(input string nm, input int nd, input bit w16);
    chk({nm, " busy"}, 32'(w16 ? if16.alu_busy : if8.alu_busy), 32'd1);
    for (int i = 1; i < nd; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " busy"}, 32'(w16 ? if16.alu_busy : if8.alu_busy), 32'd1);
    end
    @(posedge clk);
    #1;
    chk({nm, " busy end"}, 32'(w16 ? if16.alu_busy : if8.alu_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    if8.alu_start = 0;  if8.alu_ctrl = 0;  if8.alu_AI = 0;  if8.alu_BI = 0;
    if8.alu_carry = 0;  if8.alu_BCD = 0;
    if16.alu_start = 0; if16.alu_ctrl = 0; if16.alu_AI = 0; if16.alu_BI = 0;
    if16.alu_carry = 0; if16.alu_BCD = 0;
    #3;
    chk("rst u8 y", 32'(if8.alu_Y), 32'd0);
    chk("rst u8 flags", 32'(if8.alu_flags), 32'd0);
    chk("rst u8 busy", 32'(if8.alu_busy), 32'd0);
    chk("rst u8 done", 32'(if8.alu_done), 32'd0);
    chk("rst u8 err", 32'(if8.alu_err), 32'd0);
    chk("rst u16 y", 32'(if16.alu_Y), 32'd0);
    chk("rst u16 busy", 32'(if16.alu_busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // binary ops, back-to-back
    issue8(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1, 8'hA0, 8'hC0, 1'b0);
    chk("u8 binary busy", 32'(if8.alu_busy), 32'd0);
    issue8(4'h5, 8'h81, 8'h00, 1'b1, 1'b0, 1, 8'h02, 8'h41, 1'b0);
    issue8(4'h6, 8'h80, 8'h00, 1'b1, 1'b0, 1, 8'h01, 8'h41, 1'b0);
    issue8(4'h4, 8'h03, 8'h00, 1'b1, 1'b0, 1, 8'h01, 8'h41, 1'b0);
    issue8(4'h8, 8'h10, 8'h01, 1'b1, 1'b0, 1, 8'h0F, 8'h01, 1'b0);

    // decimal ADC/SBC
    issue8(4'h0, 8'h58, 8'h46, 1'b1, 1'b1, 1, 8'h05, 8'h41, 1'b0);
    bcd_wait("u8 bcd adc", 2, 1'b0);
    issue8(4'h8, 8'h46, 8'h12, 1'b1, 1'b1, 1, 8'h34, 8'h01, 1'b0);
    bcd_wait("u8 bcd sbc", 2, 1'b0);
    issue8(4'h8, 8'h12, 8'h21, 1'b1, 1'b1, 1, 8'h91, 8'h80, 1'b0);
    bcd_wait("u8 bcd sbc borrow", 2, 1'b0);

    // rotate and logic ops; C must come from the flags, not alu_carry
    issue8(4'h7, 8'h01, 8'h00, 1'b1, 1'b0, 1, 8'h80, 8'h81, 1'b0);
    issue8(4'h3, 8'hF0, 8'h0F, 1'b0, 1'b0, 1, 8'h00, 8'h03, 1'b0);
    issue8(4'h2, 8'hFF, 8'h0F, 1'b0, 1'b0, 1, 8'hF0, 8'h81, 1'b0);
    issue8(4'h1, 8'h21, 8'h04, 1'b0, 1'b1, 1, 8'h25, 8'h01, 1'b0);
    issue8(4'h9, 8'hAA, 8'h55, 1'b1, 1'b0, 1, 8'h25, 8'h01, 1'b1);

    // start while busy is dropped and operand changes after acceptance are ignored
    issue8(4'h0, 8'h15, 8'h27, 1'b0, 1'b1, 1, 8'h42, 8'h00, 1'b0);
    issue8(4'h1, 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("u8 ignore busy end", 32'(if8.alu_busy), 32'd0);

    // reset in the middle of a decimal run
    issue8(4'h0, 8'h33, 8'h44, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0);
    chk("u8 busy before rst", 32'(if8.alu_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst u8 y", 32'(if8.alu_Y), 32'd0);
    chk("mid rst u8 flags", 32'(if8.alu_flags), 32'd0);
    chk("mid rst u8 busy", 32'(if8.alu_busy), 32'd0);
    chk("mid rst u8 done", 32'(if8.alu_done), 32'd0);
    chk("mid rst u8 err", 32'(if8.alu_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    issue8(4'h0, 8'h01, 8'h01, 1'b0, 1'b0, 1, 8'h02, 8'h00, 1'b0);

    // WIDTH=16
    issue16(4'h0, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 8'h03, 1'b0);
    bcd_wait("u16 bcd adc", 4, 1'b1);
    issue16(4'hF, 16'h1234, 16'h5678, 1'b1, 1'b0, 16'h0000, 8'h03, 1'b1);
    issue16(4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 8'hC0, 1'b0);
    issue16(4'hB, 16'h1234, 16'h5678, 1'b1, 1'b0, 16'h8000, 8'hC0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("u8 pending completions", 32'(q8.size()), 32'd0);
    chk("u16 pending completions", 32'(q16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised-width ALU for the 6502 datapath, with a start/busy/done handshake.
- Binary operations complete in one cycle.
- Decimal (BCD) ADC/SBC is computed iteratively, one nibble per cycle, least significant digit first.
- Holds the N/V/Z/C flags register in the processor status layout and retains flags an operation does not affect.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- DIGITS, WIDTH/4, number of BCD digits; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_start  in  1  start request; accepted only while alu_busy=0
- alu_ctrl  in  4  opcode, sampled with an accepted start
- alu_AI  in  WIDTH  operand A, sampled with an accepted start
- alu_BI  in  WIDTH  operand B, sampled with an accepted start
- alu_carry  in  1  carry in, sampled with an accepted start
- alu_BCD  in  1  decimal mode, sampled with an accepted start; affects ADC/SBC only
- alu_busy  out  1  operation in progress
- alu_done  out  1  one-cycle pulse when alu_Y/alu_flags become valid
- alu_err  out  1  high together with alu_done for a reserved opcode
- alu_flags  out  8  bit7 N, bit6 V, bit1 Z, bit0 C; bits 5..2 are always 0
- alu_Y  out  WIDTH  result, held until the next completion

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM to IDLE; latched operands cleared. Reset mid-operation aborts it and no done pulse is produced.
- Opcodes:
  - 0000 ADC: A+B+C
  - 0001 ORA
  - 0010 EOR
  - 0011 AND
  - 0100 LSR: 0 shifts into msb, C=A[0]
  - 0101 ASL: C=A[W-1]
  - 0110 ROL: C shifts into lsb, C=A[W-1]
  - 0111 ROR: C shifts into msb, C=A[0]
  - 1000 SBC: A+~B+C
  - 1001..1111 reserved
  - Shifts and rotates use A only.
- FSM states: IDLE, BCD_RUN.
- IDLE, start=1, binary op or logic op:
  - At the next edge, alu_Y and alu_flags update and alu_done=1 for one cycle.
  - alu_busy stays 0, so back-to-back starts every cycle are legal.
- IDLE, start=1, ADC/SBC with alu_BCD=1:
  - Operands are latched and the FSM moves to BCD_RUN; alu_busy=1 from the next cycle.
  - BCD_RUN processes digit k on the k-th cycle.
  - After the DIGITS-th digit: alu_Y and alu_flags update, alu_done pulses, alu_busy drops and the FSM returns to IDLE. Done is visible DIGITS cycles after the start edge.
- BCD ADC digit: s=a+b+cin; if s>9 then s=s+6 and cout=1, else cout=0; keep the low 4 bits.
- BCD SBC digit: borrow_in = ~cin at digit 0; d=a-b-borrow; if d<0 then d=d+10 and borrow=1; final C = ~borrow.
- Flags:
  - N = Y msb; Z = (Y==0).
  - C: as defined per op; ORA/EOR/AND leave C unchanged.
  - V: ADC/SBC only, from the binary sum of the same operands, V=(A^R)&(B'^R) at the msb, where B' is B for ADC and ~B for SBC. Computed identically in BCD mode. All other ops leave V unchanged.
- Reserved opcode: completes like a binary op, with alu_err=1 alongside alu_done; alu_Y and alu_flags are unchanged.
- alu_start while busy: ignored entirely, with no queueing and no effect on the operation in flight.
- Input changes after acceptance have no effect; operands are latched.
- Invalid BCD digits (>9) are processed by the same rules; the result is as computed with no error flag.
- DIGITS=1 gives a one-cycle BCD latency, with busy high for that one cycle.

Test Plan:
- WIDTH=8, ADC binary, A=0x50, B=0x50, C=0 -> next cycle alu_Y=0xA0, N=1 V=1 Z=0 C=0, alu_done one cycle, busy never high.
- WIDTH=8, BCD ADC, A=0x58, B=0x46, C=1 -> busy high 2 cycles, then alu_Y=0x05, C=1, Z=0, done pulses once, 2 cycles after start.
- WIDTH=8, BCD SBC, A=0x46, B=0x12, C=1 -> alu_Y=0x34, C=1. Then A=0x12, B=0x21, C=1 -> alu_Y=0x91, C=0, N=1.
- WIDTH=8, ROR A=0x01, C=1 -> alu_Y=0x80, C=1, N=1. Then AND A=0xF0, B=0x0F -> alu_Y=0x00, Z=1, C stays 1, N=0.
- WIDTH=8, BCD ADC start, then start with ORA one cycle later -> ORA ignored, only one done, BCD result correct. A second BCD op with rst pulsed mid-run -> all outputs 0, no done.
- WIDTH=16, BCD ADC, A=0x9999, B=0x0001, C=0 -> 4 busy cycles, alu_Y=0x0000, C=1, Z=1. Opcode 0xF -> alu_err=1 with alu_done, Y and flags unchanged.
